// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: post-reset flush, load-use bubbles,
// branch flushes and data-memory wait freezes with a sticky timeout flag.
module pipeline_ctrl #(
   parameter int MAX_WAIT    = 16,
   parameter int FILL_CYCLES = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        id_valid_i,
   input  logic [4:0]  id_rs_i,
   input  logic [4:0]  id_rt_i,
   input  logic        id_use_rt_i,
   input  logic        ex_valid_i,
   input  logic        ex_memread_i,
   input  logic [4:0]  ex_rt_i,
   input  logic        branch_taken_i,
   input  logic        exmem_valid_i,
   input  logic        mem_req_i,
   input  logic        mem_ack_i,
   output logic        pc_write_o,
   output logic        ifid_write_o,
   output logic        ifid_flush_o,
   output logic        idex_bubble_o,
   output logic        pipe_freeze_o,
   output logic        memwb_valid_o,
   output logic        mem_err_o,
   output logic [15:0] stall_cnt_o,
   output logic [1:0]  state_o
);

   localparam int FW = $clog2(FILL_CYCLES + 1);
   localparam int WW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      ST_FILL     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [FW-1:0] fill_cnt_r;
   logic [WW-1:0] wait_cnt_r;
   logic          mem_err_r;
   logic [15:0]   stall_cnt_r;

   logic load_use_s;
   logic mem_stall_s;
   logic run_pc_write_s;
   logic run_ifid_write_s;
   logic run_flush_s;
   logic run_bubble_s;

   assign load_use_s  = id_valid_i & ex_valid_i & ex_memread_i & (ex_rt_i != 5'd0) &
                        ((ex_rt_i == id_rs_i) | (id_use_rt_i & (ex_rt_i == id_rt_i)));
   assign mem_stall_s = mem_req_i & exmem_valid_i & ~mem_ack_i;

   // Unfrozen decode: load-use bubble wins over a branch flush
   always_comb begin
      run_pc_write_s   = 1'b1;
      run_ifid_write_s = 1'b1;
      run_flush_s      = 1'b0;
      run_bubble_s     = 1'b0;
      if (load_use_s) begin
         run_pc_write_s   = 1'b0;
         run_ifid_write_s = 1'b0;
         run_bubble_s     = 1'b1;
      end else if (branch_taken_i) begin
         run_flush_s = 1'b1;
      end else begin
         run_flush_s = 1'b0;
      end
   end

   // Next-state and control outputs; reset forces the flush view
   always_comb begin
      state_s       = state_r;
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_freeze_o = 1'b0;
      memwb_valid_o = 1'b0;
      state_o       = state_r;
      if (!rst_i) begin
         state_s       = ST_FILL;
         ifid_flush_o  = 1'b1;
         idex_bubble_o = 1'b1;
         state_o       = ST_FILL;
      end else begin
         case (state_r)
            ST_FILL: begin
               ifid_flush_o  = 1'b1;
               idex_bubble_o = 1'b1;
               if (fill_cnt_r == FW'(FILL_CYCLES - 1)) begin
                  state_s = ST_RUN;
               end else begin
                  state_s = ST_FILL;
               end
            end
            ST_RUN: begin
               if (mem_stall_s) begin
                  pc_write_o    = 1'b0;
                  ifid_write_o  = 1'b0;
                  pipe_freeze_o = 1'b1;
                  state_s       = ST_MEM_WAIT;
               end else begin
                  pc_write_o    = run_pc_write_s;
                  ifid_write_o  = run_ifid_write_s;
                  ifid_flush_o  = run_flush_s;
                  idex_bubble_o = run_bubble_s;
                  memwb_valid_o = exmem_valid_i;
               end
            end
            ST_MEM_WAIT: begin
               if (!mem_ack_i) begin
                  pc_write_o    = 1'b0;
                  ifid_write_o  = 1'b0;
                  pipe_freeze_o = 1'b1;
               end else begin
                  pc_write_o    = run_pc_write_s;
                  ifid_write_o  = run_ifid_write_s;
                  ifid_flush_o  = run_flush_s;
                  idex_bubble_o = run_bubble_s;
                  memwb_valid_o = exmem_valid_i;
                  state_s       = ST_RUN;
               end
            end
            default: begin
               ifid_flush_o  = 1'b1;
               idex_bubble_o = 1'b1;
               state_s       = ST_FILL;
            end
         endcase
      end
   end

   // State, flush/wait counters, sticky timeout and stall statistics
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_r     <= ST_FILL;
         fill_cnt_r  <= '0;
         wait_cnt_r  <= '0;
         mem_err_r   <= 1'b0;
         stall_cnt_r <= 16'd0;
      end else begin
         state_r <= state_s;
         if (state_r == ST_FILL && state_s == ST_FILL) begin
            fill_cnt_r <= fill_cnt_r + FW'(1);
         end else begin
            fill_cnt_r <= '0;
         end
         if (state_r == ST_RUN && state_s == ST_MEM_WAIT) begin
            wait_cnt_r <= '0;
         end else if (state_r == ST_MEM_WAIT && wait_cnt_r != WW'(MAX_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
         // Set on the wait cycle that brings the count to MAX_WAIT
         if (state_r == ST_MEM_WAIT && wait_cnt_r >= WW'(MAX_WAIT - 1)) begin
            mem_err_r <= 1'b1;
         end else begin
            mem_err_r <= mem_err_r;
         end
         if (state_r != ST_FILL && !pc_write_o && stall_cnt_r != 16'hFFFF) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign mem_err_o   = mem_err_r;
   assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized scoreboard bench for pipeline_ctrl against a cycle-level
// behavioural model of the controller rules.
module tb_pipeline_ctrl;

   localparam int MAX_WAIT    = 16;
   localparam int FILL_CYCLES = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid = 1'b0, id_use_rt = 1'b0;
   logic [4:0]  id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
   logic        ex_valid = 1'b0, ex_memread = 1'b0, branch_taken = 1'b0;
   logic        exmem_valid = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
   logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
   logic        memwb_valid, mem_err;
   logic [15:0] stall_cnt;
   logic [1:0]  state;

   typedef struct packed {
      logic        pc_write;
      logic        ifid_write;
      logic        ifid_flush;
      logic        idex_bubble;
      logic        pipe_freeze;
      logic        memwb_valid;
      logic        mem_err;
      logic [15:0] stall_cnt;
      logic [1:0]  state;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Model state: flush cycles left, waiting on memory, wait length, flags
   int   m_fill_left = FILL_CYCLES;
   bit   m_waiting   = 1'b0;
   int   m_wait_len  = 0;
   bit   m_err       = 1'b0;
   int   m_stalls    = 0;

   pipeline_ctrl #(.MAX_WAIT(MAX_WAIT), .FILL_CYCLES(FILL_CYCLES)) dut (
      .clk_i(clk), .rst_i(rst),
      .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rt_i(id_use_rt),
      .ex_valid_i(ex_valid), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
      .branch_taken_i(branch_taken), .exmem_valid_i(exmem_valid),
      .mem_req_i(mem_req), .mem_ack_i(mem_ack),
      .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
      .idex_bubble_o(idex_bubble), .pipe_freeze_o(pipe_freeze),
      .memwb_valid_o(memwb_valid), .mem_err_o(mem_err),
      .stall_cnt_o(stall_cnt), .state_o(state)
   );

   always #5 clk = ~clk;

   // Expected response for the inputs currently applied, then advance model
   task automatic model_cycle();
      exp_t e;
      bit hazard, mstall;
      hazard = id_valid && ex_valid && ex_memread && ex_rt != 5'd0 &&
               (ex_rt == id_rs || (id_use_rt && ex_rt == id_rt));
      mstall = mem_req && exmem_valid && !mem_ack;
      e.mem_err   = m_err;
      e.stall_cnt = 16'(m_stalls);
      e.pipe_freeze = 1'b0; e.memwb_valid = 1'b0; e.ifid_flush = 1'b0;
      e.idex_bubble = 1'b0; e.pc_write = 1'b1; e.ifid_write = 1'b1;
      if (!rst || m_fill_left > 0) begin
         e.ifid_flush = 1'b1; e.idex_bubble = 1'b1; e.state = 2'd0;
      end else if ((m_waiting && !mem_ack) || (!m_waiting && mstall)) begin
         e.pc_write = 1'b0; e.ifid_write = 1'b0; e.pipe_freeze = 1'b1;
         e.state = m_waiting ? 2'd2 : 2'd1;
      end else begin
         e.state = m_waiting ? 2'd2 : 2'd1;
         e.memwb_valid = exmem_valid;
         if (hazard) begin
            e.pc_write = 1'b0; e.ifid_write = 1'b0; e.idex_bubble = 1'b1;
         end else if (branch_taken) begin
            e.ifid_flush = 1'b1;
         end
      end
      exp_q.push_back(e);
      if (!rst) begin
         m_fill_left = FILL_CYCLES; m_waiting = 1'b0; m_wait_len = 0;
         m_err = 1'b0; m_stalls = 0;
      end else if (m_fill_left > 0) begin
         m_fill_left--;
      end else begin
         if (!e.pc_write && m_stalls < 65535) m_stalls++;
         if (m_waiting) begin
            if (m_wait_len < MAX_WAIT) m_wait_len++;
            if (m_wait_len >= MAX_WAIT) m_err = 1'b1;
            if (mem_ack) m_waiting = 1'b0;
         end else if (mstall) begin
            m_waiting = 1'b1; m_wait_len = 0;
         end
      end
   endtask

   task automatic step(input logic r, input int req_pct, input int ack_pct);
      rst          = r;
      id_valid     = ($urandom_range(99) < 80);
      id_rs        = 5'($urandom_range(3));
      id_rt        = 5'($urandom_range(3));
      id_use_rt    = $urandom_range(1);
      ex_valid     = ($urandom_range(99) < 80);
      ex_memread   = $urandom_range(1);
      ex_rt        = 5'($urandom_range(3));
      branch_taken = ($urandom_range(99) < 30);
      exmem_valid  = ($urandom_range(99) < (req_pct == 100 ? 100 : 75));
      mem_req      = ($urandom_range(99) < req_pct);
      mem_ack      = ($urandom_range(99) < ack_pct);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: compare the applied cycle's outputs mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("state",       int'(state),       int'(e.state));
         chk("pc_write",    int'(pc_write),    int'(e.pc_write));
         chk("ifid_write",  int'(ifid_write),  int'(e.ifid_write));
         chk("ifid_flush",  int'(ifid_flush),  int'(e.ifid_flush));
         chk("idex_bubble", int'(idex_bubble), int'(e.idex_bubble));
         chk("pipe_freeze", int'(pipe_freeze), int'(e.pipe_freeze));
         chk("memwb_valid", int'(memwb_valid), int'(e.memwb_valid));
         chk("mem_err",     int'(mem_err),     int'(e.mem_err));
         chk("stall_cnt",   int'(stall_cnt),   int'(e.stall_cnt));
      end
   end

   initial begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) step(1'b0, 30, 50);
      for (int i = 0; i < 80; i++) step(1'b1, 30, 50);
      // Load-use on r8 via rs, then same with r0 destination
      rst = 1'b1; mem_req = 1'b0; mem_ack = 1'b0; exmem_valid = 1'b1;
      id_valid = 1'b1; ex_valid = 1'b1; ex_memread = 1'b1; branch_taken = 1'b0;
      id_use_rt = 1'b0; id_rt = 5'd1;
      ex_rt = 5'd8; id_rs = 5'd8; model_cycle(); @(posedge clk); #1;
      ex_rt = 5'd0; id_rs = 5'd0; model_cycle(); @(posedge clk); #1;
      // Hazard + branch + memory stall together, ack after 3 frozen cycles
      ex_rt = 5'd8; id_rs = 5'd8; branch_taken = 1'b1; mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin model_cycle(); @(posedge clk); #1; end
      mem_ack = 1'b1; model_cycle(); @(posedge clk); #1;
      id_valid = 1'b0; mem_req = 1'b0; model_cycle(); @(posedge clk); #1;
      // Memory timeout, then sticky flag after ack
      for (int i = 0; i < 20; i++) step(1'b1, 100, 0);
      step(1'b1, 100, 100);
      for (int i = 0; i < 20; i++) step(1'b1, 30, 50);
      // Reset in the middle of a memory wait
      for (int i = 0; i < 4; i++) step(1'b1, 100, 0);
      step(1'b0, 100, 0);
      for (int i = 0; i < 400; i++) step(1'b1, $urandom_range(60), $urandom_range(20, 90));
      for (int i = 0; i < 30; i++) step(1'b1, 100, 3);
      step(1'b0, 30, 50);
      for (int i = 0; i < 100; i++) step(1'b1, 40, 40);
      repeat (3) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: actual %0d pending required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
